// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings,
// FSM states, mode-register value and timing defaults.
package sdram_pkg;

    // {cs, ras, cas, we}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_INH   = 4'b1111;

    // CAS latency 2, burst length 1
    localparam logic [12:0] MODE_REG = 13'h020;
    // a[10] selects all banks on PRECHARGE
    localparam logic [12:0] A10_ALL  = 13'h0400;

    localparam int DEF_INIT_WAIT    = 200;
    localparam int DEF_REF_INTERVAL = 780;
    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_RFC        = 7;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MRS,
        S_IDLE,
        S_ACT,
        S_RDWR,
        S_CAS_WAIT,
        S_PRE,
        S_REF
    } state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator: a down-counter that raises a sticky
// pending flag on each expiry; the controller clears it when it refreshes.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic pending
);

    localparam logic [15:0] RELOAD = 16'(REF_INTERVAL - 1);

    logic [15:0] cnt;

    // Count while enabled; a fresh expiry wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt     <= RELOAD;
            pending <= 1'b0;
        end else begin
            if (clr)
                pending <= 1'b0;
            if (cnt == 16'd0) begin
                cnt     <= RELOAD;
                pending <= 1'b1;
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

endmodule

// File: rtl/sdram_ctrl.sv
// Single-access close-page SDRAM controller (32-bit, CL2, burst 1).
// All SDRAM pins are registered; every command is decided one edge early.
module sdram_ctrl
    import sdram_pkg::*;
#(
    parameter int INIT_WAIT    = DEF_INIT_WAIT,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RFC        = DEF_T_RFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        cke,
    output logic        cs,
    output logic        ras,
    output logic        cas,
    output logic        we,
    output logic [12:0] a,
    output logic [1:0]  ba,
    output logic [3:0]  dqm,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    input  logic [31:0] dq_in
);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  cmd;
    logic        init_done;
    logic        rd_cap;
    logic        ref_pending;
    logic        ref_clr;
    logic        lat_we;
    logic [1:0]  lat_ba;
    logic [8:0]  lat_col;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        unused_addr_bits;

    assign {cs, ras, cas, we} = cmd;
    assign req_ready = (state == S_IDLE) && !ref_pending;
    assign ref_clr   = (state == S_IDLE) && ref_pending;
    assign unused_addr_bits = ^{req_addr[31:26], req_addr[1:0]};

    sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (init_done),
        .clr     (ref_clr),
        .pending (ref_pending)
    );

    // Main sequencer: init, idle arbitration, close-page access and refresh
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT_WAIT;
            cnt        <= 16'(INIT_WAIT);
            cke        <= 1'b0;
            cmd        <= CMD_INH;
            a          <= '0;
            ba         <= '0;
            dqm        <= 4'hF;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            rd_cap     <= 1'b0;
            init_done  <= 1'b0;
            lat_we     <= 1'b0;
            lat_ba     <= '0;
            lat_col    <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
        end else begin
            cke        <= 1'b1;
            cmd        <= CMD_NOP;
            dqm        <= 4'hF;
            dq_oe      <= 1'b0;
            resp_valid <= 1'b0;
            // read data arrives two cycles after READ (CL2)
            if (rd_cap) begin
                resp_valid <= 1'b1;
                resp_rdata <= dq_in;
                rd_cap     <= 1'b0;
            end
            case (state)
                S_INIT_WAIT: begin
                    if (cnt == 16'd0) begin
                        cmd   <= CMD_PRE;
                        a     <= A10_ALL;
                        ba    <= '0;
                        cnt   <= 16'(T_RP - 1);
                        state <= S_INIT_PRE;
                    end else cnt <= cnt - 16'd1;
                end
                S_INIT_PRE: begin
                    if (cnt == 16'd0) begin
                        cmd   <= CMD_REF;
                        cnt   <= 16'(T_RFC - 1);
                        state <= S_INIT_REF1;
                    end else cnt <= cnt - 16'd1;
                end
                S_INIT_REF1: begin
                    if (cnt == 16'd0) begin
                        cmd   <= CMD_REF;
                        cnt   <= 16'(T_RFC - 1);
                        state <= S_INIT_REF2;
                    end else cnt <= cnt - 16'd1;
                end
                S_INIT_REF2: begin
                    if (cnt == 16'd0) begin
                        cmd   <= CMD_MRS;
                        a     <= MODE_REG;
                        ba    <= '0;
                        cnt   <= 16'd1;
                        state <= S_INIT_MRS;
                    end else cnt <= cnt - 16'd1;
                end
                S_INIT_MRS: begin
                    if (cnt == 16'd0) begin
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end else cnt <= cnt - 16'd1;
                end
                S_IDLE: begin
                    if (ref_pending) begin
                        cmd   <= CMD_REF;
                        cnt   <= 16'(T_RFC - 1);
                        state <= S_REF;
                    end else if (req_valid) begin
                        lat_we    <= req_we;
                        lat_ba    <= req_addr[12:11];
                        lat_col   <= req_addr[10:2];
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        cmd       <= CMD_ACT;
                        a         <= req_addr[25:13];
                        ba        <= req_addr[12:11];
                        cnt       <= 16'(T_RCD - 1);
                        state     <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (cnt == 16'd0) begin
                        a  <= {4'b0000, lat_col};
                        ba <= lat_ba;
                        if (lat_we) begin
                            cmd    <= CMD_WRITE;
                            dq_oe  <= 1'b1;
                            dq_out <= lat_wdata;
                            dqm    <= ~lat_wstrb;
                        end else begin
                            cmd <= CMD_READ;
                            dqm <= 4'h0;
                        end
                        state <= S_RDWR;
                    end else cnt <= cnt - 16'd1;
                end
                S_RDWR: begin
                    if (lat_we) begin
                        cmd        <= CMD_PRE;
                        a          <= '0;
                        ba         <= lat_ba;
                        resp_valid <= 1'b1;
                        cnt        <= 16'(T_RP - 1);
                        state      <= S_PRE;
                    end else begin
                        state <= S_CAS_WAIT;
                    end
                end
                S_CAS_WAIT: begin
                    // precharge overlaps the CL2 data cycle
                    cmd    <= CMD_PRE;
                    a      <= '0;
                    ba     <= lat_ba;
                    rd_cap <= 1'b1;
                    cnt    <= 16'(T_RP - 1);
                    state  <= S_PRE;
                end
                S_PRE, S_REF: begin
                    if (cnt == 16'd0) state <= S_IDLE;
                    else cnt <= cnt - 16'd1;
                end
                default: begin
                    state <= S_INIT_WAIT;
                    cnt   <= 16'(INIT_WAIT);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: SDRAM device model, response scoreboard, directed
// accesses with hand-computed bus fields and read data.
module tb_sdram_ctrl;

    localparam int IW   = 10;
    localparam int RI   = 20;
    localparam int TRFC = 7;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_INH = 4'b1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        cke, cs, ras, cas, we;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [3:0]  dqm;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic [31:0] dq_in = 32'h0BAD0BAD;
    logic [3:0]  cmd;

    assign cmd = {cs, ras, cas, we};

    always #5 clk = ~clk;

    sdram_ctrl #(
        .INIT_WAIT(IW), .REF_INTERVAL(RI), .T_RCD(2), .T_RP(2), .T_RFC(TRFC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .cke(cke), .cs(cs), .ras(ras), .cas(cas), .we(we),
        .a(a), .ba(ba), .dqm(dqm), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
    );

    typedef struct {
        logic        we;
        logic [1:0]  ba;
        logic [12:0] row;
        logic [8:0]  col;
        logic [3:0]  dqm;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int resp_seen = 0;
    int ref_count = 0;
    int rfc_left = 0;

    logic [31:0] mem [logic [23:0]];
    logic [12:0] open_row [4];
    logic        in_access = 1'b0;
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [31:0] s1_d = '0, s2_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Device model, response scoreboard and bus-rule monitors
    always @(negedge clk) begin
        bus_t        b;
        resp_t       r;
        logic [23:0] key;
        logic [31:0] w;
        logic        nv;
        logic [31:0] nd;
        nv = 1'b0;
        nd = 32'h0BAD0BAD;
        if (resp_valid) begin
            resp_seen++;
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual=resp_valid rdata=%h required=no response", resp_rdata);
            end else begin
                r = resp_q.pop_front();
                if (r.chk) chk("resp_rdata", resp_rdata, r.data);
            end
        end
        if (dq_oe) chk("dq_oe_only_on_write", cmd, C_WR);
        if (rfc_left > 0) begin
            chk("ready_low_in_trfc", req_ready, 1'b0);
            rfc_left--;
        end
        case (cmd)
            C_ACT: begin
                open_row[ba] = a;
                in_access = 1'b1;
            end
            C_RD, C_WR: begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected actual=cmd %b required=none", cmd);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_fields", {cmd == C_WR, ba, open_row[ba], a, dqm, dq_oe},
                        {b.we, b.ba, b.row, 4'b0000, b.col, b.dqm, b.we});
                    key = {ba, open_row[ba], a[8:0]};
                    w = mem.exists(key) ? mem[key] : 32'h0;
                    if (cmd == C_WR) begin
                        chk("write_data", dq_out, b.wdata);
                        for (int i = 0; i < 4; i++)
                            if (!dqm[i]) w[i*8 +: 8] = dq_out[i*8 +: 8];
                        mem[key] = w;
                    end else begin
                        nv = 1'b1;
                        nd = w;
                    end
                end
            end
            C_PRE: in_access = 1'b0;
            C_REF: begin
                chk("refresh_idle_only", {in_access, req_ready}, 2'b00);
                rfc_left = TRFC - 1;
                ref_count++;
            end
            C_INH: in_access = 1'b0;
            default: ;
        endcase
        dq_in = s2_v ? s2_d : 32'h0BAD0BAD;
        s2_v = s1_v;
        s2_d = s1_d;
        s1_v = nv;
        s1_d = nd;
    end

    task automatic check_reset_outputs();
        chk("reset_ctl", {cke, cmd, a, ba, dqm, dq_oe, req_ready, resp_valid},
            {1'b0, C_INH, 13'd0, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0});
        chk("reset_dq_out", dq_out, 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
    endtask

    // Call right after reset is released (cycle 0); ends at the first IDLE negedge
    task automatic init_check();
        logic [3:0] e;
        @(negedge clk);
        chk("init_c0_cke", cke, 1'b0);
        for (int k = 1; k <= IW + 19; k++) begin
            @(negedge clk);
            e = C_NOP;
            if (k == IW + 1) e = C_PRE;
            if (k == IW + 3 || k == IW + 10) e = C_REF;
            if (k == IW + 17) e = C_MRS;
            chk("init_trace", {cke, cmd, req_ready}, {1'b1, e, k == IW + 19});
            if (k == IW + 1) chk("init_pre_a10", a[10], 1'b1);
            if (k == IW + 17) chk("init_mrs_a_ba", {a, ba}, {13'h020, 2'd0});
        end
    endtask

    function automatic logic [6:0] timed_exp(input logic w, input int c);
        logic [3:0] ec;
        ec = C_NOP;
        if (c == 1) ec = C_ACT;
        if (c == 3) ec = w ? C_WR : C_RD;
        if ((w && c == 4) || (!w && c == 5)) ec = C_PRE;
        // {cmd, req_ready, resp_valid, dq_oe}
        return {ec, w ? (c == 6) : (c == 7), w ? (c == 4) : (c == 6), w && (c == 3)};
    endfunction

    task automatic run(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [1:0] eba, input logic [12:0] erow,
                       input logic [8:0] ecol, input logic [3:0] edqm,
                       input logic [31:0] erd, input logic timed);
        bus_t  bt;
        resp_t rt;
        int    n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=req_ready 0 required=1 within 100 cycles");
            return;
        end
        req_valid = 1'b1;
        req_we    = w;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        bt.we = w; bt.ba = eba; bt.row = erow; bt.col = ecol; bt.dqm = edqm; bt.wdata = wd;
        bus_q.push_back(bt);
        rt.chk = !w; rt.data = erd;
        resp_q.push_back(rt);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (timed) begin
            for (int c = 1; c <= (w ? 6 : 7); c++) begin
                @(negedge clk);
                chk(w ? "write_timing" : "read_timing", {cmd, req_ready, resp_valid, dq_oe},
                    timed_exp(w, c));
            end
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1);
    end

    initial begin
        int saved;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        init_check();

        // cycle-exact write then read right after init
        run(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 2'd2, 13'd0, 9'd1, 4'h0, 32'h0, 1'b1);
        run(1'b0, 32'h0000_1004, 32'h0, 4'h0, 2'd2, 13'd0, 9'd1, 4'h0, 32'hDEAD_BEEF, 1'b1);
        // byte-masked overwrite
        run(1'b1, 32'h0000_1004, 32'h1122_3344, 4'b0101, 2'd2, 13'd0, 9'd1, 4'b1010, 32'h0, 1'b0);
        run(1'b0, 32'h0000_1004, 32'h0, 4'h0, 2'd2, 13'd0, 9'd1, 4'h0, 32'hDE22_BE44, 1'b0);
        // address extremes
        run(1'b1, 32'h03FF_FFFC, 32'hA5A5_0001, 4'hF, 2'd3, 13'd8191, 9'd511, 4'h0, 32'h0, 1'b0);
        run(1'b1, 32'h0000_0000, 32'h5A5A_0002, 4'hF, 2'd0, 13'd0, 9'd0, 4'h0, 32'h0, 1'b0);
        run(1'b0, 32'h03FF_FFFC, 32'h0, 4'h0, 2'd3, 13'd8191, 9'd511, 4'h0, 32'hA5A5_0001, 1'b0);
        run(1'b0, 32'h0000_0000, 32'h0, 4'h0, 2'd0, 13'd0, 9'd0, 4'h0, 32'h5A5A_0002, 1'b0);
        // zero strobe still completes and changes nothing
        run(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 2'd0, 13'd0, 9'd0, 4'hF, 32'h0, 1'b0);
        run(1'b0, 32'h0000_0000, 32'h0, 4'h0, 2'd0, 13'd0, 9'd0, 4'h0, 32'h5A5A_0002, 1'b0);
        run(1'b1, 32'h0000_2000, 32'h0000_CAFE, 4'hF, 2'd0, 13'd1, 9'd0, 4'h0, 32'h0, 1'b0);
        run(1'b0, 32'h0000_2000, 32'h0, 4'h0, 2'd0, 13'd1, 9'd0, 4'h0, 32'h0000_CAFE, 1'b0);
        // ignored address bits
        run(1'b0, 32'hFC00_1007, 32'h0, 4'h0, 2'd2, 13'd0, 9'd1, 4'h0, 32'hDE22_BE44, 1'b0);

        repeat (30) @(negedge clk);
        chk("resp_drain", resp_q.size(), 0);
        chk("bus_drain", bus_q.size(), 0);
        chk("refresh_seen", ref_count > 0, 1'b1);

        // reset in c3 of a read: transaction dropped, init repeats
        while (!req_ready) @(negedge clk);
        begin
            bus_t bt;
            bt.we = 1'b0; bt.ba = 2'd2; bt.row = 13'd0; bt.col = 9'd1; bt.dqm = 4'h0; bt.wdata = '0;
            bus_q.push_back(bt);
        end
        saved = resp_seen;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_1004;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        init_check();
        chk("no_resp_after_reset", resp_seen, saved);
        chk("bus_after_reset", bus_q.size(), 0);

        run(1'b0, 32'h0000_1004, 32'h0, 4'h0, 2'd2, 13'd0, 9'd1, 4'h0, 32'hDE22_BE44, 1'b1);
        repeat (10) @(negedge clk);
        chk("final_drain", resp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
